// File: rtl/cb_rd_responder.sv
// cb_rd_responder: read-only core-bus responder backed by a word array with a backdoor load port.
// Optional: define CB_RSP_RANGE_CHECK_EN to answer reads at or above 4*MEM_WORDS with CB_SLVERR.
package cb_rd_responder_pkg;
  typedef enum logic [1:0] {
    CB_OKAY   = 2'b00,
    CB_EXOKAY = 2'b01,
    CB_SLVERR = 2'b10,
    CB_DECERR = 2'b11
  } cb_resp_e;

  typedef struct packed {
    logic        rd_addr_valid;
    logic [31:0] rd_addr;
    logic [2:0]  rd_size;
    logic        rd_ready;
    logic        wr_addr_valid;
    logic [31:0] wr_addr;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_resp_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        rd_addr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    cb_resp_e    rd_resp;
    logic        wr_addr_ready;
    logic        wr_ready;
    logic        wr_resp_valid;
    cb_resp_e    wr_resp;
  } s_cb_miso_t;
endpackage

module cb_rd_responder
  import cb_rd_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int MAX_OT    = 4,
  parameter int LATENCY   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  s_cb_mosi_t                   cb_mosi_i,
  output s_cb_miso_t                   cb_miso_o,
  input  logic                         load_en_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_data_i
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MAX_OT + 1);
  localparam int PW = (MAX_OT > 1) ? $clog2(MAX_OT) : 1;

  logic [31:0]   mem_q [MEM_WORDS];
  logic [31:0]   fifo_data_q [MAX_OT];
  cb_resp_e      fifo_resp_q [MAX_OT];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0] ot_cnt_q, ot_cnt_d;

  logic          addr_ready, rsp_valid, accept, pop;
  logic [AW-1:0] rd_idx;
  logic [31:0]   acc_data;
  cb_resp_e      acc_resp;
  logic          push;
  logic [31:0]   push_data;
  cb_resp_e      push_resp;
  logic          unused_mosi;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on valid, and both outputs are forced low while rst is high.
  assign addr_ready  = !rst && (ot_cnt_q < CW'(MAX_OT));
  assign rsp_valid   = !rst && (fifo_cnt_q != '0);
  assign accept      = addr_ready && cb_mosi_i.rd_addr_valid;
  assign pop         = rsp_valid && cb_mosi_i.rd_ready;
  assign rd_idx      = cb_mosi_i.rd_addr[AW+1:2];
  assign unused_mosi = ^cb_mosi_i;

  always_comb begin
    acc_data = mem_q[rd_idx];
    acc_resp = CB_OKAY;
`ifdef CB_RSP_RANGE_CHECK_EN
    if (|cb_mosi_i.rd_addr[31:AW+2]) begin
      acc_data = '0;
      acc_resp = CB_SLVERR;
    end
`endif
  end

  // The array read happens at acceptance, so a same-edge backdoor write yields old data.
  if (LATENCY == 1) begin : g_no_pipe
    assign push      = accept;
    assign push_data = acc_data;
    assign push_resp = acc_resp;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q, vld_d;
    logic [31:0]        data_q [LATENCY-1];
    logic [31:0]        data_d [LATENCY-1];
    cb_resp_e           resp_q [LATENCY-1];
    cb_resp_e           resp_d [LATENCY-1];

    always_comb begin
      vld_d     = '0;
      data_d    = data_q;
      resp_d    = resp_q;
      vld_d[0]  = accept;
      data_d[0] = acc_data;
      resp_d[0] = acc_resp;
      for (int i = 1; i < LATENCY - 1; i++) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = data_q[i-1];
        resp_d[i] = resp_q[i-1];
      end
      if (rst) vld_d = '0;
    end

    always_ff @(posedge clk) begin
      vld_q  <= vld_d;
      data_q <= data_d;
      resp_q <= resp_d;
    end

    assign push      = vld_q[LATENCY-2];
    assign push_data = data_q[LATENCY-2];
    assign push_resp = resp_q[LATENCY-2];
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    ot_cnt_d   = ot_cnt_q + CW'(accept) - CW'(pop);
    if (push) wr_ptr_d = (wr_ptr_q == PW'(MAX_OT - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(MAX_OT - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (rst) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      ot_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    fifo_cnt_q <= fifo_cnt_d;
    ot_cnt_q   <= ot_cnt_d;
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_resp_q[wr_ptr_q] <= push_resp;
    end
    if (load_en_i) mem_q[load_addr_i] <= load_data_i;
  end

  always_comb begin
    cb_miso_o               = '0;
    cb_miso_o.rd_addr_ready = addr_ready;
    cb_miso_o.rd_valid      = rsp_valid;
    if (rsp_valid) begin
      cb_miso_o.rd_data = fifo_data_q[rd_ptr_q];
      cb_miso_o.rd_resp = fifo_resp_q[rd_ptr_q];
    end
  end
endmodule

// File: doc/cb_rd_responder.md
CB_RD_RESPONDER -- requirements
Module: cb_rd_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning number of 32-bit words in the internal array (power of 2, >=4).
REQ-002 SHALL have parameter MAX_OT, default 4, meaning the maximum number of accepted read requests not yet delivered (>=1).
REQ-003 SHALL have parameter LATENCY, default 1, meaning the cycles from address acceptance to response availability (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port cb_mosi_i, input, s_cb_mosi_t, the core bus request from the initiator.
REQ-007 SHALL have port cb_miso_o, output, s_cb_miso_t, the core bus reply to the initiator.
REQ-008 SHALL have port load_en_i, input, 1, the backdoor word write strobe.
REQ-009 SHALL have port load_addr_i, input, $clog2(MEM_WORDS), the backdoor word index.
REQ-010 SHALL have port load_data_i, input, 32, the backdoor write data.
REQ-011 SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.

Function
REQ-012 SHALL drive cb_miso_o.rd_addr_ready = (ot_cnt < MAX_OT), where ot_cnt counts requests accepted and not yet popped.
REQ-013 SHALL accept a request on a cycle where cb_mosi_i.rd_addr_valid and rd_addr_ready are both high.
REQ-014 SHALL index the array with rd_addr[$clog2(MEM_WORDS)+1:2].
REQ-015 SHALL ignore rd_addr[1:0] and rd_size, and SHALL always return a full word.
REQ-016 SHALL make each accepted request's response available exactly LATENCY cycles after acceptance, through a LATENCY-stage valid/data/resp pipeline.
REQ-017 SHALL hold available responses in an in-order response FIFO of MAX_OT entries.
REQ-018 SHALL drive cb_miso_o.rd_valid = FIFO not empty, with rd_data and rd_resp taken from the FIFO head.
REQ-019 SHALL pop the FIFO head when rd_valid and cb_mosi_i.rd_ready are both high.
REQ-020 SHALL hold the head stable while rd_valid is high and rd_ready is low.
REQ-021 SHALL deliver responses strictly in acceptance order.
REQ-022 SHALL update ot_cnt each cycle by next = ot_cnt + accept - pop; a same-cycle accept and pop SHALL leave ot_cnt unchanged.
REQ-023 SHALL never overflow the FIFO, since ot_cnt bounds pipeline plus FIFO occupancy; a MAX_OT-deep FIFO with rd_ready held low SHALL deassert rd_addr_ready.
REQ-024 SHALL keep cb_miso_o.rd_data at 0 when rd_valid is low.
REQ-025 SHALL tie all write-channel ready/valid fields of cb_miso_o to 0 and SHALL ignore the write-channel fields of cb_mosi_i.
REQ-026 SHALL write load_data_i into the array at load_addr_i on a cycle where load_en_i is high.
REQ-027 SHALL return the old (pre-write) data when a read is accepted in the same cycle as a backdoor write to the same word.
REQ-028 SHALL set rd_resp = CB_OKAY on every response, except as stated in REQ-034.

Reset
REQ-029 SHALL, while rst is high, clear ot_cnt, pipeline valids, FIFO pointers and occupancy.
REQ-030 SHALL drive all cb_miso_o fields to 0 during reset.
REQ-031 SHALL drive rd_addr_ready = 1 in the first cycle after reset release.
REQ-032 SHALL silently discard in-flight requests when reset is asserted mid-operation; none SHALL be delivered after release.
REQ-033 SHALL NOT clear array contents on reset.

Configuration
REQ-034 SHALL, with macro CB_RSP_RANGE_CHECK_EN defined, return rd_resp = CB_SLVERR and rd_data = 0 for any request with rd_addr >= 4*MEM_WORDS, with the same latency and ordering as other responses.
REQ-035 SHALL, without CB_RSP_RANGE_CHECK_EN, ignore the upper address bits, wrap the address modulo 4*MEM_WORDS, and always respond CB_OKAY.

Verification
REQ-036 SHALL cover: load word 3 = 0xDEADBEEF, read addr 0xC with rd_ready=1 and LATENCY=1 -> rd_valid exactly 1 cycle after acceptance, data 0xDEADBEEF, resp CB_OKAY.
REQ-037 SHALL cover: MAX_OT=4, rd_ready=0, 6 back-to-back requests -> 4 accepted and rd_addr_ready=0; raise rd_ready -> 4 responses in order, then remaining 2 accepted.
REQ-038 SHALL cover: continuous requests to 0x0,0x4,0x8,... with rd_ready=1 -> one accept and one response per cycle, ot_cnt constant at LATENCY.
REQ-039 SHALL cover: with CB_RSP_RANGE_CHECK_EN and MEM_WORDS=1024, read 0x1000 -> CB_SLVERR, data 0; without the macro -> data of word 0, CB_OKAY.
REQ-040 SHALL cover: load word 5 = 0x1 in the same cycle as a read of 0x14 (old value 0x2) -> response 0x2; the next read -> 0x1.
REQ-041 SHALL cover: assert rst with 3 requests outstanding -> no rd_valid after release, rd_addr_ready=1, and a new request returns correct data.
